// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, PSW bit positions and FSM state for the ALU command driver
package alu_pkg;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SUB      = 4'd1;
    localparam logic [3:0] OP_AND      = 4'd2;
    localparam logic [3:0] OP_OR       = 4'd3;
    localparam logic [3:0] OP_NOT      = 4'd4;
    localparam logic [3:0] OP_SHIFT_L  = 4'd6;
    localparam logic [3:0] OP_SHIFT_R  = 4'd7;
    localparam logic [3:0] OP_SHIFT_RA = 4'd8;

    localparam int PSW_CARRY   = 0;
    localparam int PSW_BORROW  = 1;
    localparam int PSW_GT      = 2;
    localparam int PSW_EQ      = 3;
    localparam int PSW_LT      = 4;
    localparam int PSW_ILLEGAL = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Opcode 5 is a hole in the map; everything above SHIFT_RA is unused.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_NOT) || ((op >= OP_SHIFT_L) && (op <= OP_SHIFT_RA));
    endfunction

endpackage

// File: rtl/alu_psw_gen.sv
// rtl/alu_psw_gen.sv - combinational PSW flags the ALU itself does not produce
module alu_psw_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [31:0]      psw
);

    logic [WIDTH-1:0] sum;
    logic             carry;

    // Carry out of A+B shows up as the truncated sum wrapping below A.
    assign sum   = a + b;
    assign carry = (sum < a);

    always_comb begin
        psw = '0;
        if (is_legal_op(cmd)) begin
            psw[PSW_CARRY]  = (cmd == OP_ADD) && carry;
            psw[PSW_BORROW] = (cmd == OP_SUB) && (a < b);
            psw[PSW_GT]     = (a > b);
            psw[PSW_EQ]     = (a == b);
            psw[PSW_LT]     = (a < b);
        end else begin
            psw[PSW_ILLEGAL] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - request/response sequencer in front of the combinational ALU
// ALU_DRV_PREFETCH_EN adds a one-entry request buffer so the next op issues on the response handshake.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [31:0]      rsp_psw,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [31:0]      req_psw;
    logic             accept, rsp_fire, capture, issue_go, iss_legal;
    logic [3:0]       iss_cmd;
    logic [WIDTH-1:0] iss_a, iss_b;
    logic [TAG_W-1:0] iss_tag;
    logic [31:0]      iss_psw;

    alu_psw_gen #(.WIDTH(WIDTH)) u_psw (
        .cmd (req_cmd),
        .a   (req_a),
        .b   (req_b),
        .psw (req_psw)
    );

    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign capture   = (state == ST_ISSUE) && (cnt <= 4'd1);
    assign iss_legal = is_legal_op(iss_cmd);

`ifdef ALU_DRV_PREFETCH_EN
    logic             buf_valid;
    logic [3:0]       buf_cmd;
    logic [WIDTH-1:0] buf_a, buf_b;
    logic [TAG_W-1:0] buf_tag;
    logic [31:0]      buf_psw;
    logic             from_buf, from_req, buf_load;

    // On the handshake edge a waiting buffer entry wins; a fresh request then refills it.
    always_comb begin
        from_buf = (state == ST_RESP) && rsp_fire && buf_valid;
        from_req = accept && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_fire && !buf_valid));
        buf_load = accept && !from_req;
        issue_go = from_buf || from_req;
        iss_cmd  = from_buf ? buf_cmd : req_cmd;
        iss_a    = from_buf ? buf_a   : req_a;
        iss_b    = from_buf ? buf_b   : req_b;
        iss_tag  = from_buf ? buf_tag : req_tag;
        iss_psw  = from_buf ? buf_psw : req_psw;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_cmd   <= '0;
            buf_a     <= '0;
            buf_b     <= '0;
            buf_tag   <= '0;
            buf_psw   <= '0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_cmd   <= req_cmd;
            buf_a     <= req_a;
            buf_b     <= req_b;
            buf_tag   <= req_tag;
            buf_psw   <= req_psw;
        end else if (from_buf) begin
            buf_valid <= 1'b0;
        end
    end
`else
    always_comb begin
        issue_go = accept;
        iss_cmd  = req_cmd;
        iss_a    = req_a;
        iss_b    = req_b;
        iss_tag  = req_tag;
        iss_psw  = req_psw;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue_go) state_nxt = iss_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: if (capture) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_fire) state_nxt = issue_go ? (iss_legal ? ST_ISSUE : ST_RESP) : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef ALU_DRV_PREFETCH_EN
        req_ready = (state == ST_IDLE) || !buf_valid;
`else
        req_ready = (state == ST_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_psw   <= '0;
            rsp_tag   <= '0;
        end else begin
            if (state == ST_ISSUE) cnt <= cnt - 4'd1;
            if (capture) begin
                rsp_data  <= alu_data;
                rsp_valid <= 1'b1;
            end
            if (rsp_fire) rsp_valid <= 1'b0;
            // Illegal ops skip the ALU entirely and answer on the accept edge.
            if (issue_go) begin
                rsp_tag <= iss_tag;
                rsp_psw <= iss_psw;
                if (iss_legal) begin
                    alu_a   <= iss_a;
                    alu_b   <= iss_b;
                    alu_cmd <= iss_cmd;
                    cnt     <= SETTLE_INIT;
                end else begin
                    rsp_data  <= '0;
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - directed bench for alu_cmd_driver with a behavioural ALU beside it
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, rsp_ready;
    logic [3:0]  req_cmd, req_tag;
    logic [63:0] req_a, req_b;

    logic        req_ready, rsp_valid;
    logic [63:0] alu_a, alu_b, alu_data, rsp_data;
    logic [3:0]  alu_cmd, rsp_tag;
    logic [31:0] rsp_psw;

    logic        r3_req_ready, r3_rsp_valid;
    logic [63:0] r3_alu_a, r3_alu_b, r3_alu_data, r3_rsp_data;
    logic [3:0]  r3_alu_cmd, r3_rsp_tag;
    logic [31:0] r3_rsp_psw;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ~a;
            4'd6:    return a << b[5:0];
            4'd7:    return a >> b[5:0];
            4'd8:    return 64'($signed(a) >>> b[5:0]);
            default: return 64'd0;
        endcase
    endfunction

    always_comb alu_data    = alu_model(alu_cmd, alu_a, alu_b);
    always_comb r3_alu_data = alu_model(r3_alu_cmd, r3_alu_a, r3_alu_b);

    alu_cmd_driver #(.WIDTH(64), .SETTLE_CYCLES(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_data(alu_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_psw(rsp_psw), .rsp_tag(rsp_tag)
    );

    alu_cmd_driver #(.WIDTH(64), .SETTLE_CYCLES(3), .TAG_W(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(r3_req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(r3_alu_a), .alu_b(r3_alu_b), .alu_cmd(r3_alu_cmd), .alu_data(r3_alu_data),
        .rsp_valid(r3_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r3_rsp_data),
        .rsp_psw(r3_rsp_psw), .rsp_tag(r3_rsp_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request on the S=1 instance, measure latency and check the response.
    task automatic run_op(input string name, input logic [3:0] cmd, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag, input int exp_lat, input logic [63:0] exp_data,
                          input logic [31:0] exp_psw);
        int lat;
        req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_tag = tag;
        chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_data"}, rsp_data, exp_data);
        chk({name, "_psw"}, 64'(rsp_psw), 64'(exp_psw));
        chk({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        @(negedge clk);
        chk({name, "_valid_clear"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_cmd = '0; req_a = '0; req_b = '0; req_tag = '0;
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_psw", 64'(rsp_psw), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_cmd", 64'(alu_cmd), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("add", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 2, 64'd0, 32'h05);
        run_op("sub", 4'd1, 64'd3, 64'd5, 4'h4, 2, 64'hFFFF_FFFF_FFFF_FFFE, 32'h12);
        run_op("and", 4'd2, 64'h30, 64'h30, 4'h5, 2, 64'h30, 32'h08);
        chk("and_alu_cmd", 64'(alu_cmd), 64'd2);
        run_op("ill5", 4'd5, 64'h1234, 64'h5678, 4'hA, 1, 64'd0, 32'h20);
        chk("ill5_alu_cmd_held", 64'(alu_cmd), 64'd2);
        chk("ill5_alu_a_held", alu_a, 64'h30);
        run_op("ill15", 4'd15, 64'd9, 64'd9, 4'hB, 1, 64'd0, 32'h20);
        run_op("sra", 4'd8, 64'h8000_0000_0000_0000, 64'd4, 4'hC, 2, 64'hF800_0000_0000_0000, 32'h04);

        // Backpressure: response must hold while rsp_ready is low.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_cmd = 4'd6; req_a = 64'd1; req_b = 64'd4; req_tag = 4'h7;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 64'(rsp_valid), 64'd1);
            chk("bp_data_held", rsp_data, 64'h10);
            chk("bp_psw_held", 64'(rsp_psw), 64'h10);
            chk("bp_req_ready_low", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_clear", 64'(rsp_valid), 64'd0);
        chk("bp_req_ready_back", 64'(req_ready), 64'd1);

        // Let both instances drain, then reset the S=3 instance mid-ISSUE.
        repeat (8) @(negedge clk);
        chk("r3_idle_ready", 64'(r3_req_ready), 64'd1);
        req_valid = 1'b1; req_cmd = 4'd0; req_a = 64'd7; req_b = 64'd8; req_tag = 4'h6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("r3_mid_issue_ready", 64'(r3_req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("r3_rst_valid", 64'(r3_rsp_valid), 64'd0);
        chk("r3_rst_alu_a", r3_alu_a, 64'd0);
        chk("r3_rst_alu_b", r3_alu_b, 64'd0);
        chk("r3_rst_alu_cmd", 64'(r3_alu_cmd), 64'd0);
        chk("r3_rst_data", r3_rsp_data, 64'd0);
        chk("r3_rst_psw", 64'(r3_rsp_psw), 64'd0);
        chk("r3_rst_tag", 64'(r3_rsp_tag), 64'd0);
        chk("r3_rst_ready", 64'(r3_req_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | r3_rsp_valid;
        end
        chk("r3_no_rsp_after_rst", 64'(seen), 64'd0);
        req_valid = 1'b1; req_cmd = 4'd0; req_a = 64'h10; req_b = 64'h20; req_tag = 4'h9;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!r3_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("r3_latency", 64'(lat), 64'd4);
        chk("r3_data", r3_rsp_data, 64'h30);
        chk("r3_psw", 64'(r3_rsp_psw), 64'h10);
        chk("r3_tag", 64'(r3_rsp_tag), 64'h9);
        @(negedge clk);
        chk("r3_valid_clear", 64'(r3_rsp_valid), 64'd0);

`ifdef ALU_DRV_PREFETCH_EN
        repeat (8) @(negedge clk);
        req_valid = 1'b1; req_cmd = 4'd0; req_a = 64'd2; req_b = 64'd3; req_tag = 4'h1;
        @(negedge clk);
        req_cmd = 4'd3; req_a = 64'hF0; req_b = 64'h0F; req_tag = 4'h2;
        chk("pf_ready_in_issue", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pf_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("pf_rsp1_tag", 64'(rsp_tag), 64'h1);
        chk("pf_rsp1_data", rsp_data, 64'd5);
        @(negedge clk);
        chk("pf_gap_valid", 64'(rsp_valid), 64'd0);
        chk("pf_second_issued", 64'(alu_cmd), 64'd3);
        @(negedge clk);
        chk("pf_rsp2_valid", 64'(rsp_valid), 64'd1);
        chk("pf_rsp2_tag", 64'(rsp_tag), 64'h2);
        chk("pf_rsp2_data", rsp_data, 64'hFF);
        @(negedge clk);
        chk("pf_done", 64'(rsp_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
